// File: rtl/knap_pkg.sv
// knap_pkg: shared state encoding and default sizing for the knapsack checker.
// Rev 1.0
`default_nettype none

package knap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam int DEF_N_ITEMS = 24;
  localparam int DEF_N_DIMS  = 2;
  localparam int DEF_COEF_W  = 5;
  localparam int DEF_ACC_W   = 9;
  localparam int DIM_VALUE   = 0;

endpackage

`default_nettype wire

// File: rtl/knap_sat_acc.sv
// knap_sat_acc: accumulator with synchronous clear that saturates at all-ones.
// Rev 1.0
`default_nettype none

module knap_sat_acc #(
  parameter int ACC_W  = 9,
  parameter int COEF_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [COEF_W-1:0] addend,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W:0] sum;

  // One guard bit catches the carry so the result clamps instead of wrapping.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - COEF_W){1'b0}}, addend};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/knap_seq_checker.sv
// knap_seq_checker: walks a selected item set, sums value and constraint coefficients, checks limits.
// Rev 1.0 -- build option KNAP_EARLY_EXIT_EN stops accumulation at the first constraint violation.
`default_nettype none

module knap_seq_checker
  import knap_pkg::*;
#(
  parameter int N_ITEMS = DEF_N_ITEMS,
  parameter int N_DIMS  = DEF_N_DIMS,
  parameter int COEF_W  = DEF_COEF_W,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(N_ITEMS)-1:0]   cfg_item,
  input  logic [$clog2(N_DIMS+1)-1:0]  cfg_dim,
  input  logic [COEF_W-1:0]            cfg_coef,
  input  logic                         lim_we,
  input  logic [$clog2(N_DIMS+1)-1:0]  lim_dim,
  input  logic [ACC_W-1:0]             lim_val,
  input  logic                         start,
  input  logic [N_ITEMS-1:0]           sel,
  output logic                         busy,
  output logic                         done,
  output logic                         valid,
  output logic [ACC_W-1:0]             total_value
);

  localparam int IDX_W = $clog2(N_ITEMS);
  localparam int DIM_W = $clog2(N_DIMS + 1);
  localparam int NDIM  = N_DIMS + 1;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [N_ITEMS-1:0] sel_q;
  logic [COEF_W-1:0]  coef [N_ITEMS][NDIM];
  logic [ACC_W-1:0]   lim  [NDIM];
  logic [ACC_W-1:0]   acc  [NDIM];
  logic [NDIM-1:0]    fit;
  logic               accept;
  logic               add_en;
  logic               last;
  logic               exit_early;
  logic               cfg_ok;
  logic               lim_ok;

  assign accept = (state == ST_IDLE) && start;
  assign add_en = (state == ST_ACCUM) && sel_q[idx];
  assign last   = (idx == IDX_W'(N_ITEMS - 1));
  assign cfg_ok = cfg_we && ({1'b0, cfg_item} < (IDX_W + 1)'(N_ITEMS))
                         && ({1'b0, cfg_dim} < (DIM_W + 1)'(NDIM));
  assign lim_ok = lim_we && ({1'b0, lim_dim} < (DIM_W + 1)'(NDIM));

`ifdef KNAP_EARLY_EXIT_EN
  logic [NDIM-1:0] over;
`endif

  for (genvar d = 0; d < NDIM; d++) begin : g_dim
    knap_sat_acc #(
      .ACC_W  (ACC_W),
      .COEF_W (COEF_W)
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept),
      .add_en (add_en),
      .addend (coef[idx][d]),
      .acc    (acc[d])
    );

    if (d == DIM_VALUE) begin : g_min
      assign fit[d] = (acc[d] >= lim[d]);
`ifdef KNAP_EARLY_EXIT_EN
      assign over[d] = 1'b0;
`endif
    end else begin : g_max
      assign fit[d] = (acc[d] <= lim[d]);
`ifdef KNAP_EARLY_EXIT_EN
      // Look ahead at the saturated sum this edge will store, so CHECK follows one edge later.
      logic [ACC_W:0]   probe;
      logic [ACC_W-1:0] probe_sat;
      assign probe     = {1'b0, acc[d]} + {{(ACC_W + 1 - COEF_W){1'b0}}, coef[idx][d]};
      assign probe_sat = probe[ACC_W] ? '1 : probe[ACC_W-1:0];
      assign over[d]   = add_en && (probe_sat > lim[d]);
`endif
    end
  end

`ifdef KNAP_EARLY_EXIT_EN
  assign exit_early = |over;
`else
  assign exit_early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        for (int d = 0; d < NDIM; d++) begin
          coef[IDX_W'(i)][DIM_W'(d)] <= '0;
        end
      end
      for (int d = 0; d < NDIM; d++) begin
        lim[DIM_W'(d)] <= '0;
      end
    end else if (state == ST_IDLE) begin
      if (cfg_ok) coef[cfg_item][cfg_dim] <= cfg_coef;
      if (lim_ok) lim[lim_dim] <= lim_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      sel_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      valid       <= 1'b0;
      total_value <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_q <= sel;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (last || exit_early) begin
            state <= ST_CHECK;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_CHECK: begin
          valid       <= &fit;
          total_value <= acc[DIM_VALUE];
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_knap_seq_checker.sv
// tb_knap_seq_checker: table vectors, corner sequences and random runs against a sum-and-clamp model.
`timescale 1ns/1ps
`default_nettype none

module tb_knap_seq_checker;

  localparam int N_ITEMS = 24;
  localparam int N_DIMS  = 2;
  localparam int COEF_W  = 7;
  localparam int ACC_W   = 9;
  localparam int NDIM    = N_DIMS + 1;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_we = 1'b0;
  logic [4:0]         cfg_item = '0;
  logic [1:0]         cfg_dim = '0;
  logic [COEF_W-1:0]  cfg_coef = '0;
  logic               lim_we = 1'b0;
  logic [1:0]         lim_dim = '0;
  logic [ACC_W-1:0]   lim_val = '0;
  logic               start = 1'b0;
  logic [N_ITEMS-1:0] sel = '0;
  logic               busy;
  logic               done;
  logic               valid;
  logic [ACC_W-1:0]   total_value;

  int m_coef [N_ITEMS][NDIM];
  int m_lim  [NDIM];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N_ITEMS-1:0] sel;
    int                 exp_valid;
    int                 exp_total;
  } vec_t;

  knap_seq_checker #(
    .N_ITEMS (N_ITEMS),
    .N_DIMS  (N_DIMS),
    .COEF_W  (COEF_W),
    .ACC_W   (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_item    (cfg_item),
    .cfg_dim     (cfg_dim),
    .cfg_coef    (cfg_coef),
    .lim_we      (lim_we),
    .lim_dim     (lim_dim),
    .lim_val     (lim_val),
    .start       (start),
    .sel         (sel),
    .busy        (busy),
    .done        (done),
    .valid       (valid),
    .total_value (total_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_ITEMS; i++)
      for (int d = 0; d < NDIM; d++) m_coef[i][d] = 0;
    for (int d = 0; d < NDIM; d++) m_lim[d] = 0;
  endtask

  function automatic int clamp(input int v);
    return (v > ACC_MAX) ? ACC_MAX : v;
  endfunction

  // Reference: plain totals of the selected items clamped to the accumulator range.
  task automatic model(input logic [N_ITEMS-1:0] s, output int e_valid, output int e_total,
                       output int e_lat);
    int sum [NDIM];
    bit stop;
    for (int d = 0; d < NDIM; d++) sum[d] = 0;
    stop  = 1'b0;
    e_lat = N_ITEMS + 1;
    for (int k = 0; k < N_ITEMS; k++) begin
      if (s[k] && !stop) begin
        for (int d = 0; d < NDIM; d++) sum[d] = sum[d] + m_coef[k][d];
`ifdef KNAP_EARLY_EXIT_EN
        for (int d = 1; d < NDIM; d++) if (clamp(sum[d]) > m_lim[d]) stop = 1'b1;
        if (stop) e_lat = k + 2;
`endif
      end
    end
    e_total = clamp(sum[0]);
    e_valid = (e_total >= m_lim[0]) ? 1 : 0;
    for (int d = 1; d < NDIM; d++) if (clamp(sum[d]) > m_lim[d]) e_valid = 0;
  endtask

  task automatic wr_coef(input int item, input int dim, input int val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_item = 5'(item); cfg_dim = 2'(dim); cfg_coef = COEF_W'(val);
    @(negedge clk);
    cfg_we = 1'b0;
    m_coef[item][dim] = val;
  endtask

  task automatic wr_lim(input int dim, input int val);
    @(negedge clk);
    lim_we = 1'b1; lim_dim = 2'(dim); lim_val = ACC_W'(val);
    @(negedge clk);
    lim_we = 1'b0;
    m_lim[dim] = val;
  endtask

  // Waits for done after a start already sampled; optionally fires writes/start mid-run.
  task automatic collect(input string tag, input int e_valid, input int e_total, input int e_lat,
                         input bit inject);
    int lat;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (done) lat = c;
      if (c == 3) check({tag, " busy mid-run"}, 32'(busy), 32'd1);
      if (inject && c == 4) begin
        cfg_we = 1'b1; cfg_item = 5'd0; cfg_dim = 2'd0; cfg_coef = '0;
        lim_we = 1'b1; lim_dim = 2'd0; lim_val = '0;
        start = 1'b1; sel = '1;
      end
      if (inject && c == 6) begin
        cfg_we = 1'b0; lim_we = 1'b0; start = 1'b0; sel = '0;
      end
      if (lat != 0) break;
    end
    check({tag, " done latency"}, 32'(lat), 32'(e_lat));
    check({tag, " valid"}, 32'(valid), 32'(e_valid));
    check({tag, " total_value"}, 32'(total_value), 32'(e_total));
    @(posedge clk);
    #1;
    check({tag, " done one-cycle"}, 32'(done), 32'd0);
    check({tag, " busy released"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input logic [N_ITEMS-1:0] s, input string tag);
    int ev, et, el;
    model(s, ev, et, el);
    @(negedge clk);
    start = 1'b1; sel = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    collect(tag, ev, et, el, 1'b0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
  endtask

  initial begin
    vec_t vt [9];
    int   ev, et, el, nd;

    vt = '{
      '{24'h3, 1, 130}, '{24'h7, 0, 130}, '{24'h1, 0, 70},  '{24'h0, 0, 0},
      '{24'h2, 0, 60},  '{24'h9, 1, 130}, '{24'hA, 1, 120}, '{24'hB, 1, 190},
      '{24'hD, 1, 130}
    };

    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset total_value", 32'(total_value), 32'd0);

    wr_lim(0, 120); wr_lim(1, 60); wr_lim(2, 60);
    wr_coef(0, 0, 70); wr_coef(0, 1, 30); wr_coef(0, 2, 20);
    wr_coef(1, 0, 60); wr_coef(1, 1, 30); wr_coef(1, 2, 40);
    wr_coef(2, 0, 0);  wr_coef(2, 1, 1);  wr_coef(2, 2, 0);
    wr_coef(3, 0, 60); wr_coef(3, 1, 0);  wr_coef(3, 2, 0);

    for (int v = 0; v < 9; v++) begin
      model(vt[v].sel, ev, et, el);
      @(negedge clk);
      start = 1'b1; sel = vt[v].sel;
      @(posedge clk);
      #1;
      start = 1'b0;
      collect($sformatf("vec%0d", v), vt[v].exp_valid, vt[v].exp_total, el, 1'b0);
    end

    // A constraint total one above its limit must fail; back at the limit it passes.
    wr_lim(1, 59);
    run(24'h3, "lim1 at 59");
    check("lim1 at 59 rejects", 32'(valid), 32'd0);
    wr_lim(1, 60);

    // Writes and start while busy must not disturb the run, the table or the limits.
    model(24'h3, ev, et, el);
    @(negedge clk);
    start = 1'b1; sel = 24'h3;
    @(posedge clk);
    #1;
    start = 1'b0;
    collect("busy-writes", 1, 130, el, 1'b1);
    count_done(30, nd);
    check("no second done", 32'(nd), 32'd0);
    run(24'h3, "table intact");

    // A coefficient write on the same edge as an accepted start is used by that run.
    m_coef[0][0] = 31;
    model(24'h1, ev, et, el);
    @(negedge clk);
    start = 1'b1; sel = 24'h1;
    cfg_we = 1'b1; cfg_item = 5'd0; cfg_dim = 2'd0; cfg_coef = COEF_W'(31);
    @(posedge clk);
    #1;
    start = 1'b0; cfg_we = 1'b0;
    collect("cfg on start edge", 0, 31, el, 1'b0);
    wr_coef(0, 0, 70);

    // Saturation: 24 x 31 must clamp to the accumulator maximum.
    for (int i = 0; i < N_ITEMS; i++) begin
      wr_coef(i, 0, 31); wr_coef(i, 1, 0); wr_coef(i, 2, 0);
    end
    wr_lim(0, 0);
    run('1, "saturation");
    check("saturated total", 32'(total_value), 32'(ACC_MAX));

    for (int r = 0; r < 20; r++) begin
      for (int w = 0; w < 6; w++)
        wr_coef($urandom_range(N_ITEMS - 1), $urandom_range(NDIM - 1),
                $urandom_range((1 << COEF_W) - 1));
      wr_lim($urandom_range(NDIM - 1), $urandom_range(ACC_MAX));
      run(N_ITEMS'($urandom), $sformatf("rand%0d", r));
    end

    // Reset in the middle of accumulation aborts silently and clears everything.
    @(negedge clk);
    start = 1'b1; sel = '1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort valid cleared", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(30, nd);
    check("abort no done", 32'(nd), 32'd0);
    run(24'h00F0F0, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
